// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative unsigned multiply/divide unit. Each clock runs one shift-add
//   (multiply) or one restoring-divide step, so an operation takes WIDTH
//   steps. Result feeds the register write-data mux. Busy stalls the PC.
//   Done is a one-cycle pulse that triggers the writeback.
//
// Ports
//   Clock      in   1      rising-edge clock
//   Reset      in   1      asynchronous, active-high; back to IDLE
//   Start      in   1      request, sampled only in IDLE or DONE
//   Op         in   2      00 MULLO, 01 MULHI, 10 DIV, 11 REM
//   OperandA   in   WIDTH  multiplicand / dividend
//   OperandB   in   WIDTH  multiplier / divisor
//   Busy       out  1      high while iterating (RUN)
//   Done       out  1      one-cycle pulse, Result valid
//   Result     out  WIDTH  selected result, held until the next DONE
//   DivByZero  out  1      DIV/REM with OperandB==0, held like Result
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   a_q, a_d;       // operand A, shifted left one bit per step
  logic [WIDTH-1:0]     b_q, b_d;       // operand B, fixed for the whole operation
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // product, or {remainder, quotient}
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 dbz_q, dbz_d;

  // ---- single iteration datapath -----------------------------------------
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     trial_sub;
  logic               trial_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] div_acc;
  logic [2*WIDTH-1:0] step_acc;
  logic               last_step;

  always_comb begin
    // Multiply: a_q already holds A << cnt. Add it in when bit cnt of B is set.
    mul_acc = b_q[cnt_q] ? (acc_q + a_q) : acc_q;

    // Restoring divide. Shift the next dividend bit (MSB first) into the
    // remainder. The trial value is one bit wider, so the compare never wraps.
    // Because a_q shifts left each step, the next dividend bit is always at
    // a_q[WIDTH-1].
    trial     = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    trial_sub = trial - {1'b0, b_q};
    trial_ge  = (trial >= {1'b0, b_q});
    // The remainder stays below B. So whichever value is kept, it fits in WIDTH bits.
    rem_next  = trial_ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
    div_acc   = {rem_next, acc_q[WIDTH-2:0], trial_ge};

    step_acc  = op_q[1] ? div_acc : mul_acc;
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  // ---- next-state / datapath control -------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          op_d  = Op;
          a_d   = {{WIDTH{1'b0}}, OperandA};
          b_d   = OperandB;
          acc_d = '0;
          cnt_d = '0;
          if (Op[1] && (OperandB == '0)) begin
            // Divide by zero skips the iterations.
            // DIV gives all-ones and REM gives the dividend.
            state_d  = S_DONE;
            result_d = Op[0] ? OperandA : {WIDTH{1'b1}};
            dbz_d    = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // Start is ignored here. A request made while busy is not queued.
        acc_d = step_acc;
        a_d   = a_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          // In both layouts, odd ops (MULHI, REM) read the upper half
          // and even ops (MULLO, DIV) read the lower half.
          result_d = op_q[0] ? step_acc[2*WIDTH-1:WIDTH] : step_acc[WIDTH-1:0];
          dbz_d    = 1'b0;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Busy      = (state_q == S_RUN);
  assign Done      = (state_q == S_DONE);
  assign Result    = result_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit. It uses directed cases and random
//   operations. Expected values come from a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'd0;
  logic [W-1:0] OperandA = '0;
  logic [W-1:0] OperandB = '0;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] Result;

  int n_chk  = 0;
  int n_fail = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .Busy(Busy), .Done(Done), .Result(Result), .DivByZero(DivByZero)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the bits above W are the div-by-zero flag, the low W bits are the result.
  function automatic logic [W:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint unsigned prod;
    prod = longint'(a) * longint'(b);
    if (op[1] && b == 0) return {1'b1, (op[0] ? a : {W{1'b1}})};
    case (op)
      2'd0:    return {1'b0, W'(prod)};
      2'd1:    return {1'b0, W'(prod >> W)};
      2'd2:    return {1'b0, W'(a / b)};
      default: return {1'b0, W'(a % b)};
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clock);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
  endtask

  // Waits for Done after a Start. In scramble mode, Start stays high and the
  // operands change during RUN. In chain mode, the next Start is put on the Done cycle.
  task automatic wait_done(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit scramble, input bit chain,
                           input logic [1:0] nop, input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [W:0] exp;
    int lat, n;
    bit got;
    exp = ref_model(op, a, b);
    lat = (op[1] && b == 0) ? 1 : W + 1;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge Clock);
      n++;
      if (Done) begin
        got = 1;
        if (chain) begin Start = 1'b1; Op = nop; OperandA = na; OperandB = nb; end
        else Start = 1'b0;
      end else begin
        chk("busy_in_run", Busy, 1);
        if (scramble) begin
          Start = 1'b1; Op = 2'($urandom); OperandA = W'($urandom); OperandB = W'($urandom);
        end else Start = 1'b0;
      end
    end
    chk("done_seen", got, 1);
    chk("latency", n, lat);
    chk("result", Result, exp[W-1:0]);
    chk("div_by_zero", DivByZero, exp[W]);
    if (!chain) begin
      @(negedge Clock);
      chk("done_one_cycle", Done, 0);
      chk("result_held", Result, exp[W-1:0]);
      chk("dbz_held", DivByZero, exp[W]);
    end
  endtask

  task automatic reset_pulse_check();
    #2 Reset = 1'b1;
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_result", Result, 0);
    chk("rst_dbz", DivByZero, 0);
    #1 Reset = 1'b0;
  endtask

  task automatic op_run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b);
    wait_done(op, a, b, 1'b0, 1'b0, 2'd0, '0, '0);
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    bit           seen;

    // Reset state at power-up.
    reset_pulse_check();

    // Multiply.
    op_run(2'd0, 16'd300, 16'd200);
    op_run(2'd1, 16'hFFFF, 16'hFFFF);
    op_run(2'd0, 16'hFFFF, 16'hFFFF);

    // Divide.
    op_run(2'd2, 16'd1000, 16'd7);
    op_run(2'd3, 16'd1000, 16'd7);
    op_run(2'd2, 16'd5, 16'd9);
    op_run(2'd3, 16'd5, 16'd9);

    // Divide by zero.
    op_run(2'd2, 16'd1234, 16'd0);
    op_run(2'd3, 16'd1234, 16'd0);

    // A reset pulse mid-cycle clears the held, non-zero result and the flag.
    @(negedge Clock);
    reset_pulse_check();

    // Start held through RUN with changing operands. Then a back-to-back Start on Done.
    issue(2'd0, 16'h1234, 16'h0567);
    wait_done(2'd0, 16'h1234, 16'h0567, 1'b1, 1'b1, 2'd2, 16'd1000, 16'd7);
    wait_done(2'd2, 16'd1000, 16'd7, 1'b0, 1'b0, 2'd0, '0, '0);

    // Reset at RUN step 8 throws the operation away.
    issue(2'd0, 16'hABCD, 16'h1357);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      Start = 1'b0;
    end
    chk("busy_before_abort", Busy, 1);
    reset_pulse_check();
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clock);
      if (Done || Busy) seen = 1;
    end
    chk("no_done_after_abort", seen, 0);
    op_run(2'd0, 16'd3, 16'd4);

    // Random operations. Small divisors and zero divisors show up often.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 20));
        2:       rb = ra;
        default: rb = W'($urandom);
      endcase
      op_run(rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
